usb_tx_sched: RTL and testbench

USB_TX_SCHED -- requirements
Module: usb_tx_sched

---
 rtl/usb_tx_sched.sv | 185 ++++++++++++++++++
 tb/tb_usb_tx_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_sched.sv
// Packet scheduler in front of usb_tx: arbitrates handshake vs data requests,
// issues packet commands, supervises start timeout and tracks the data toggle.
module usb_tx_sched #(
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic [1:0] hs_code,
    input  logic       data_req,
    input  logic       toggle_clr,
    input  logic [6:0] Buffer_Occupancy,
    input  logic       TX_Transfer_Active,
    input  logic       TX_Error,
    output logic [2:0] TX_Packet,
    output logic       busy,
    output logic       hs_done,
    output logic       data_done,
    output logic       tx_fail,
    output logic       req_drop,
    output logic       data_toggle
);

    localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_END,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          hs_pend_q, hs_pend_d;
    logic          data_pend_q, data_pend_d;
    logic [1:0]    code_q, code_d;
    logic          cls_hs_q, cls_hs_d;
    logic [2:0]    pkt_q, pkt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          tog_q, tog_d;
    logic          hs_done_q, hs_done_d;
    logic          data_done_q, data_done_d;
    logic          fail_q, fail_d;
    logic          drop_q, drop_d;

    logic grant_hs, grant_data, hs_bad, data_bad, timeout;
    logic hs_in_service, data_in_service;

    assign grant_hs        = (state_q == S_IDLE) && hs_pend_q;
    assign grant_data      = (state_q == S_IDLE) && !hs_pend_q && data_pend_q;
    assign hs_bad          = (code_q == 2'b11);
    assign data_bad        = (Buffer_Occupancy == '0);
    assign timeout         = (cnt_q == CW'(START_TIMEOUT));
    assign hs_in_service   = (state_q != S_IDLE) && cls_hs_q;
    assign data_in_service = (state_q != S_IDLE) && !cls_hs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hs_pend_q   <= 1'b0;
            data_pend_q <= 1'b0;
            code_q      <= '0;
            cls_hs_q    <= 1'b0;
            pkt_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            tog_q       <= 1'b0;
            hs_done_q   <= 1'b0;
            data_done_q <= 1'b0;
            fail_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hs_pend_q   <= hs_pend_d;
            data_pend_q <= data_pend_d;
            code_q      <= code_d;
            cls_hs_q    <= cls_hs_d;
            pkt_q       <= pkt_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            tog_q       <= tog_d;
            hs_done_q   <= hs_done_d;
            data_done_q <= data_done_d;
            fail_q      <= fail_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if ((grant_hs && !hs_bad) || (grant_data && !data_bad))
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // An Active seen on the timeout cycle still counts as a start.
                if (TX_Transfer_Active)
                    state_d = S_WAIT_END;
                else if (timeout)
                    state_d = S_IDLE;
            end
            S_WAIT_END: begin
                if (!TX_Transfer_Active)
                    state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hs_pend_d   = hs_pend_q;
        data_pend_d = data_pend_q;
        code_d      = code_q;
        cls_hs_d    = cls_hs_q;
        pkt_d       = pkt_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        tog_d       = tog_q;
        hs_done_d   = 1'b0;
        data_done_d = 1'b0;
        fail_d      = 1'b0;
        drop_d      = (hs_req && (hs_pend_q || hs_in_service)) ||
                      (data_req && (data_pend_q || data_in_service));

        if (grant_hs) begin
            hs_pend_d = 1'b0;
            cls_hs_d  = 1'b1;
            pkt_d     = 3'(code_q) + 3'd3;
            cnt_d     = CW'(1);
            err_d     = 1'b0;
            fail_d    = hs_bad;
        end else if (grant_data) begin
            data_pend_d = 1'b0;
            cls_hs_d    = 1'b0;
            pkt_d       = 3'd1 + {2'b00, tog_q};
            cnt_d       = CW'(1);
            err_d       = 1'b0;
            fail_d      = data_bad;
        end

        // New requests only register when their class is idle.
        if (hs_req && !hs_pend_q && !hs_in_service) begin
            hs_pend_d = 1'b1;
            code_d    = hs_code;
        end
        if (data_req && !data_pend_q && !data_in_service)
            data_pend_d = 1'b1;

        unique case (state_q)
            S_ISSUE: begin
                cnt_d = cnt_q + CW'(1);
                if (!TX_Transfer_Active && timeout)
                    fail_d = 1'b1;
            end
            S_WAIT_END: begin
                if (TX_Error)
                    err_d = 1'b1;
            end
            S_DONE: begin
                fail_d      = err_q;
                hs_done_d   = !err_q && cls_hs_q;
                data_done_d = !err_q && !cls_hs_q;
                if (!err_q && !cls_hs_q)
                    tog_d = !tog_q;
            end
            default: ;
        endcase

        if (toggle_clr)
            tog_d = 1'b0;

        TX_Packet = (state_q == S_ISSUE) ? pkt_q : 3'd0;
        busy      = (state_q != S_IDLE) || hs_pend_q || data_pend_q;
    end

    assign hs_done     = hs_done_q;
    assign data_done   = data_done_q;
    assign tx_fail     = fail_q;
    assign req_drop    = drop_q;
    assign data_toggle = tog_q;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed bench for usb_tx_sched; expected values are hand-derived from the
// request/grant/issue/done cycle timing.
module tb_usb_tx_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs_req;
    logic [1:0] hs_code;
    logic       data_req;
    logic       toggle_clr;
    logic [6:0] Buffer_Occupancy;
    logic       TX_Transfer_Active;
    logic       TX_Error;
    logic [2:0] TX_Packet;
    logic       busy;
    logic       hs_done;
    logic       data_done;
    logic       tx_fail;
    logic       req_drop;
    logic       data_toggle;

    int n_cmp = 0;
    int n_bad = 0;

    usb_tx_sched #(.START_TIMEOUT(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .hs_req             (hs_req),
        .hs_code            (hs_code),
        .data_req           (data_req),
        .toggle_clr         (toggle_clr),
        .Buffer_Occupancy   (Buffer_Occupancy),
        .TX_Transfer_Active (TX_Transfer_Active),
        .TX_Error           (TX_Error),
        .TX_Packet          (TX_Packet),
        .busy               (busy),
        .hs_done            (hs_done),
        .data_done          (data_done),
        .tx_fail            (tx_fail),
        .req_drop           (req_drop),
        .data_toggle        (data_toggle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pulses(input string tag, input int hd, input int dd, input int tf);
        check({tag, ".hs_done"}, int'(hs_done), hd);
        check({tag, ".data_done"}, int'(data_done), dd);
        check({tag, ".tx_fail"}, int'(tx_fail), tf);
    endtask

    // Entered with the request pending; the next edge grants (or is already past it).
    task automatic xfer(input string tag, input int pkt, input bit is_hs,
                        input bit err, input int tog_after);
        tick();
        check({tag, ".pkt0"}, int'(TX_Packet), pkt);
        tick();
        check({tag, ".pkt1"}, int'(TX_Packet), pkt);
        tick();
        check({tag, ".pkt2"}, int'(TX_Packet), pkt);
        TX_Transfer_Active = 1'b1;
        tick();
        check({tag, ".pkt_drop"}, int'(TX_Packet), 0);
        check({tag, ".busy"}, int'(busy), 1);
        for (int i = 0; i < 99; i++) begin
            TX_Error = err && (i == 50);
            tick();
        end
        TX_Error = 1'b0;
        TX_Transfer_Active = 1'b0;
        tick();
        check_pulses({tag, ".in_done"}, 0, 0, 0);
        tick();
        check_pulses({tag, ".done"}, (is_hs && !err) ? 1 : 0,
                     (!is_hs && !err) ? 1 : 0, err ? 1 : 0);
        check({tag, ".toggle"}, int'(data_toggle), tog_after);
        tick();
        check_pulses({tag, ".after"}, 0, 0, 0);
    endtask

    initial begin
        int  n3;
        bit  seen;

        rst = 1'b1;
        hs_req = 1'b1;
        hs_code = 2'b00;
        data_req = 1'b1;
        toggle_clr = 1'b0;
        Buffer_Occupancy = 7'd5;
        TX_Transfer_Active = 1'b0;
        TX_Error = 1'b0;
        tick();
        tick();
        hs_req = 1'b0;
        data_req = 1'b0;
        rst = 1'b0;
        check("rst.pkt", int'(TX_Packet), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.toggle", int'(data_toggle), 0);
        check("rst.drop", int'(req_drop), 0);
        check_pulses("rst", 0, 0, 0);

        // Data DATA0 then DATA1
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        check("d1.busy_pend", int'(busy), 1);
        check("d1.pkt_pend", int'(TX_Packet), 0);
        xfer("d1", 1, 1'b0, 1'b0, 1);

        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        xfer("d2", 2, 1'b0, 1'b0, 0);

        // Simultaneous: handshake NAK first, then data
        hs_req = 1'b1;
        hs_code = 2'b01;
        data_req = 1'b1;
        tick();
        hs_req = 1'b0;
        data_req = 1'b0;
        xfer("hs_nak", 4, 1'b1, 1'b0, 0);
        xfer("d3", 1, 1'b0, 1'b0, 1);

        // Data with empty buffer is rejected
        Buffer_Occupancy = 7'd0;
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        tick();
        check("empty.fail", int'(tx_fail), 1);
        check("empty.pkt", int'(TX_Packet), 0);
        check("empty.busy", int'(busy), 0);
        check("empty.toggle", int'(data_toggle), 1);
        tick();
        check("empty.fail_off", int'(tx_fail), 0);
        Buffer_Occupancy = 7'd5;

        // Invalid handshake code
        hs_req = 1'b1;
        hs_code = 2'b11;
        tick();
        hs_req = 1'b0;
        tick();
        check("hs11.fail", int'(tx_fail), 1);
        check("hs11.pkt", int'(TX_Packet), 0);
        tick();
        check("hs11.fail_off", int'(tx_fail), 0);

        // Start timeout: ACK held for 16 cycles then fails
        hs_req = 1'b1;
        hs_code = 2'b00;
        tick();
        hs_req = 1'b0;
        n3 = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (TX_Packet == 3'd3)
                n3++;
            if (tx_fail)
                seen = 1'b1;
        end
        check("to.cycles", n3, 16);
        check("to.fail_seen", int'(seen), 1);
        check("to.pkt", int'(TX_Packet), 0);
        check("to.toggle", int'(data_toggle), 1);

        // TX_Error during data transfer
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        xfer("derr", 2, 1'b0, 1'b1, 1);

        toggle_clr = 1'b1;
        tick();
        toggle_clr = 1'b0;
        check("tclr.toggle", int'(data_toggle), 0);

        // Duplicate handshake request, then reset in WAIT_END
        data_toggle_set: begin
            data_req = 1'b1;
            tick();
            data_req = 1'b0;
            xfer("d4", 1, 1'b0, 1'b0, 1);
        end
        hs_req = 1'b1;
        hs_code = 2'b01;
        tick();
        tick();
        hs_req = 1'b0;
        check("dup.drop", int'(req_drop), 1);
        check("dup.pkt", int'(TX_Packet), 4);
        tick();
        check("dup.drop_off", int'(req_drop), 0);
        TX_Transfer_Active = 1'b1;
        tick();
        tick();
        check("wr.pkt_wait", int'(TX_Packet), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        TX_Transfer_Active = 1'b0;
        check("wr.pkt", int'(TX_Packet), 0);
        check("wr.busy", int'(busy), 0);
        check("wr.toggle", int'(data_toggle), 0);
        check("wr.drop", int'(req_drop), 0);
        check_pulses("wr", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_pulses("wr.quiet", 0, 0, 0);
            check("wr.quiet.busy", int'(busy), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
